// File: rtl/beta_alu_issue.sv
// Beta OP/OPC issue stage: decodes one instruction into ALU operands (S1), then
// captures the ALU result into a writeback packet (S2). Both sides are valid/ready.
module beta_alu_issue #(
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] ILLEGAL_RESULT = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_ra_data,
    input  logic [DATA_W-1:0] in_rb_data,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_fn,
    input  logic [DATA_W-1:0] alu_c,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic              out_illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        fn;
        logic [4:0]        rc;
        logic              illegal;
    } s1_t;

    localparam logic [4:0] R31 = 5'd31;

    logic              s1_valid;
    s1_t               s1;
    s1_t               dec;
    logic              s2_adv;
    logic              accept;

    logic [5:0]        opcode;
    logic              is_op;
    logic              is_opc;
    logic              fn_reserved;
    logic [DATA_W-1:0] lit_sext;
    logic              unused_ra_idx;

    // Ra/Rb indices are resolved by the register file upstream; only the data arrives here.
    assign unused_ra_idx = ^in_instr[20:16];

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    assign opcode      = in_instr[31:26];
    assign is_op       = (opcode[5:4] == 2'b10);
    assign is_opc      = (opcode[5:4] == 2'b11);
    assign fn_reserved = (opcode[2:0] == 3'b111);
    assign lit_sext    = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};

    always_comb begin
        // NOTE: every field gets a default before any branch so no latch is inferred.
        dec         = '0;
        dec.rc      = in_instr[25:21];
        dec.illegal = 1'b1;
        if ((is_op || is_opc) && !fn_reserved) begin
            dec.illegal = 1'b0;
            dec.fn      = opcode[3:0];
            dec.a       = in_ra_data;
            dec.b       = is_opc ? lit_sext : in_rb_data;
        end
    end

    // S1: decoded operands, held while the output side stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the S1 payload is reset too, because it drives alu_* directly and
            // those must read zero while in reset.
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (accept) begin
            // NOTE: non-blocking updates let S1 take the new word on the same edge that
            // S2 samples the old S1 contents, giving full throughput with no bubble.
            s1_valid <= 1'b1;
            s1       <= dec;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    assign alu_a  = s1.a;
    assign alu_b  = s1.b;
    assign alu_fn = s1.fn;

    // S2: writeback packet; payload only changes when a real S1 entry moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_rc      <= '0;
            out_data    <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_rc      <= s1.rc;
                out_data    <= s1.illegal ? ILLEGAL_RESULT : alu_c;
                out_we      <= !s1.illegal && (s1.rc != R31);
                out_illegal <= s1.illegal;
            end
        end
    end

endmodule

// File: tb/tb_beta_alu_issue.sv
// Self-checking bench for beta_alu_issue: directed plan scenarios plus randomized
// traffic with random backpressure, scored against an instruction-level model.
`timescale 1ns/1ps
module tb_beta_alu_issue;

    typedef struct packed {
        logic [4:0]  rc;
        logic [31:0] data;
        logic        we;
        logic        ill;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_ra_data;
    logic [31:0] in_rb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_fn;
    logic [31:0] alu_c;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rc;
    logic [31:0] out_data;
    logic        out_we;
    logic        out_illegal;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   stop_bp;
    pkt_t exp_q[$];
    pkt_t got_q[$];
    int   acc_cyc[$];
    int   ret_cyc[$];

    always #5 clk = ~clk;

    beta_alu_issue #(.DATA_W(32), .ILLEGAL_RESULT(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_ra_data(in_ra_data), .in_rb_data(in_rb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_rc(out_rc),
        .out_data(out_data), .out_we(out_we), .out_illegal(out_illegal)
    );

    // Beta ALU behaviour, standing in for the external combinational ALU.
    function automatic logic [31:0] alu_ref(input logic [3:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
        case (fn)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a * b;
            4'h3:    return (b == 32'h0) ? 32'h0 : a / b;
            4'h4:    return {31'b0, a == b};
            4'h5:    return {31'b0, $signed(a) < $signed(b)};
            4'h6:    return {31'b0, $signed(a) <= $signed(b)};
            4'h8:    return a & b;
            4'h9:    return a | b;
            4'hA:    return a ^ b;
            4'hB:    return ~(a ^ b);
            4'hC:    return a << b[4:0];
            4'hD:    return a >> b[4:0];
            4'hE:    return 32'($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    assign alu_c = alu_ref(alu_fn, alu_a, alu_b);

    // Instruction-level expectation: what the register file should receive.
    function automatic pkt_t model(input logic [31:0] instr, input logic [31:0] ra,
                                   input logic [31:0] rb);
        logic [5:0]  op;
        logic [31:0] b;
        int          lit;
        bit          legal;
        pkt_t        p;
        op     = instr[31:26];
        lit    = $signed(instr[15:0]);
        legal  = op[5] && (op[3:0] != 4'd7) && (op[3:0] != 4'd15);
        b      = op[4] ? 32'(lit) : rb;
        p.rc   = instr[25:21];
        p.ill  = !legal;
        p.data = legal ? alu_ref(op[3:0], ra, b) : 32'h0;
        p.we   = legal && (instr[25:21] != 5'd31);
        return p;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [15:0] lit);
        return {op, rc, 5'd2, lit};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        op = 6'($urandom);
        if ($urandom_range(0, 3) != 0) op[5] = 1'b1;
        return {op, 5'($urandom), 5'($urandom), 16'($urandom)};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_instr, in_ra_data, in_rb_data));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_rc, out_data, out_we, out_illegal});
                ret_cyc.push_back(cyc);
            end
        end
    end

    task automatic flush();
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); ret_cyc.delete();
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] ra, input logic [31:0] rb);
        bit done = 1'b0;
        in_valid = 1'b1; in_instr = instr; in_ra_data = ra; in_rb_data = rb;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (!done) begin fails++; $display("FAIL send_accept got=timeout exp=accepted instr=%h", instr); end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((out_valid || got_q.size() < exp_q.size()) && n < 300) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
        tests++;
        if (n >= 300) begin fails++; $display("FAIL %s_drain got=timeout exp=drained", name); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_ra_data = '0; in_rb_data = '0;
        out_ready = 1'b0;
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if ({out_rc, out_data, out_we, out_illegal} !== 39'h0) begin
            fails++; $display("FAIL reset_out_pkt got=%h exp=0", {out_rc, out_data, out_we, out_illegal}); end
        tests++; if ({alu_a, alu_b, alu_fn} !== 68'h0) begin
            fails++; $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_a, alu_b, alu_fn); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add();
        flush(); out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(6'h20, 5'd3, 16'h0); in_ra_data = 32'd5; in_rb_data = 32'd7;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests++; if ({alu_fn, alu_a, alu_b} !== {4'h0, 32'd5, 32'd7}) begin
            fails++; $display("FAIL add_s1 got=%h/%h/%h exp=0/5/7", alu_fn, alu_a, alu_b); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_early_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        tests++; if ({out_valid, out_rc, out_data, out_we, out_illegal} !== {1'b1, 5'd3, 32'd12, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_out got=v%b rc%0d d%0d we%b il%b exp=v1 rc3 d12 we1 il0",
                              out_valid, out_rc, out_data, out_we, out_illegal); end
        @(posedge clk); #1;
    endtask

    task automatic test_opc();
        logic [5:0]  ops [2] = '{6'h31, 6'h3C};
        logic [15:0] lits[2] = '{16'hFFFE, 16'h0004};
        logic [31:0] ras [2] = '{32'd10, 32'd1};
        logic [31:0] bs  [2] = '{32'hFFFF_FFFE, 32'h4};
        logic [31:0] exps[2] = '{32'd12, 32'd16};
        flush(); out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = mk(ops[i], 5'd4, lits[i]); in_ra_data = ras[i];
            in_rb_data = $urandom;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            tests++; if (alu_b !== bs[i]) begin fails++; $display("FAIL opc%0d_alu_b got=%h exp=%h", i, alu_b, bs[i]); end
            @(negedge clk);
            tests++; if ({out_valid, out_data, out_we} !== {1'b1, exps[i], 1'b1}) begin
                fails++; $display("FAIL opc%0d_out got=v%b d%0d we%b exp=v1 d%0d we1", i, out_valid, out_data, out_we, exps[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [5:0]  ops[4] = '{6'h27, 6'h3F, 6'h05, 6'h20};
        logic [4:0]  rcs[4] = '{5'd7, 5'd9, 5'd1, 5'd31};
        logic [34:0] exp;
        flush(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = mk(ops[i], rcs[i], 16'h1234);
            in_ra_data = 32'd100; in_rb_data = 32'd23;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                tests++; if ({alu_fn, alu_a, alu_b} !== 68'h0) begin
                    fails++; $display("FAIL ill%0d_s1 got=%h/%h/%h exp=0/0/0", i, alu_fn, alu_a, alu_b); end
            end
            @(negedge clk);
            exp = (i < 3) ? {1'b1, 32'd0, 1'b0, 1'b1} : {1'b1, 32'd123, 1'b0, 1'b0};
            tests++; if ({out_valid, out_data, out_we, out_illegal} !== exp || out_rc !== rcs[i]) begin
                fails++; $display("FAIL ill%0d_out got=v%b d%0d we%b il%b rc%0d exp=%h rc%0d",
                                  i, out_valid, out_data, out_we, out_illegal, out_rc, exp, rcs[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ra[4];
        logic [31:0] rb[4];
        pkt_t        snap;
        logic [31:0] a_snap;
        flush(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
        send(mk(6'h20, 5'd10, 16'h0), ra[0], rb[0]);
        out_ready = 1'b0;
        send(mk(6'h20, 5'd11, 16'h0), ra[1], rb[1]);
        in_valid = 1'b1; in_instr = mk(6'h20, 5'd12, 16'h0); in_ra_data = ra[2]; in_rb_data = rb[2];
        @(negedge clk);
        snap = {out_rc, out_data, out_we, out_illegal}; a_snap = alu_a;
        tests++; if (snap !== pkt_t'({5'd10, ra[0] + rb[0], 1'b1, 1'b0})) begin
            fails++; $display("FAIL bp_first got=%h exp rc10 data=%h", snap, ra[0] + rb[0]); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++; $display("FAIL bp_stall%0d got=rdy%b v%b exp=rdy0 v1", k, in_ready, out_valid); end
            tests++; if ({out_rc, out_data, out_we, out_illegal} !== snap || alu_a !== a_snap) begin
                fails++; $display("FAIL bp_hold%0d got=%h/%h exp=%h/%h", k,
                                  {out_rc, out_data, out_we, out_illegal}, alu_a, snap, a_snap); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(mk(6'h20, 5'd12, 16'h0), ra[2], rb[2]);
        send(mk(6'h20, 5'd13, 16'h0), ra[3], rb[3]);
        wait_drain("bp");
        tests++; if (got_q.size() != 4) begin fails++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== pkt_t'({5'(10 + i), ra[i] + rb[i], 1'b1, 1'b0}) || ret_cyc[i] != ret_cyc[0] + i) begin
                fails++; $display("FAIL bp_pkt%0d got=%h@%0d exp rc%0d data=%h@%0d", i, got_q[i], ret_cyc[i],
                                  10 + i, ra[i] + rb[i], ret_cyc[0] + i); end
        end
    endtask

    task automatic test_back_to_back();
        flush(); out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = rand_instr(); in_ra_data = $urandom; in_rb_data = $urandom;
            @(negedge clk);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("b2b");
        tests++; if (got_q.size() != 8 || exp_q.size() != 8) begin
            fails++; $display("FAIL b2b_count got=%0d exp=8 (accepted %0d)", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i] || ret_cyc[i] != acc_cyc[0] + 2 + i) begin
                fails++; $display("FAIL b2b_pkt%0d got=%h@%0d exp=%h@%0d", i, got_q[i], ret_cyc[i],
                                  exp_q[i], acc_cyc[0] + 2 + i); end
        end
    endtask

    task automatic test_random();
        flush(); stop_bp = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send(rand_instr(), $urandom, $urandom);
                end
                stop_bp = 1'b1;
            end
            begin
                while (!stop_bp) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand");
        tests++; if (got_q.size() != 150 || exp_q.size() != 150) begin
            fails++; $display("FAIL rand_count got=%0d exp=150 (accepted %0d)", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL rand_pkt%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ra;
        logic [31:0] rb;
        flush(); out_ready = 1'b0;
        send(mk(6'h20, 5'd1, 16'h0), 32'd3, 32'd4);
        send(mk(6'h21, 5'd6, 16'h0), 32'd50, 32'd8);
        tests++; if (out_valid !== 1'b1 || alu_fn !== 4'h1) begin
            fails++; $display("FAIL rst_full got=v%b fn%h exp=v1 fn1", out_valid, alu_fn); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || alu_fn !== 4'h0 || alu_a !== 32'h0) begin
            fails++; $display("FAIL rst_async got=v%b fn%h a%h exp=v0 fn0 a0", out_valid, alu_fn, alu_a); end
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1; flush();
        ra = $urandom; rb = $urandom;
        in_valid = 1'b1; in_instr = mk(6'h2A, 5'd8, 16'h0); in_ra_data = ra; in_rb_data = rb;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || alu_fn !== 4'hA) begin
            fails++; $display("FAIL rst_next_s1 got=v%b fn%h exp=v0 fnA", out_valid, alu_fn); end
        @(negedge clk);
        tests++; if ({out_valid, out_rc, out_data, out_we} !== {1'b1, 5'd8, ra ^ rb, 1'b1}) begin
            fails++; $display("FAIL rst_next_out got=v%b rc%0d d%h exp=v1 rc8 d%h", out_valid, out_rc, out_data, ra ^ rb); end
        repeat (4) @(posedge clk);
        #1;
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL rst_stale got=%0d exp=1 packets", got_q.size()); end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_opc();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/beta_alu_issue.md
Name: beta_alu_issue

Overview:
- Issue/decode front end for the Beta OP/OPC datapath.
- Accepts one Beta instruction word plus register-file read data over a valid/ready handshake.
- Decodes the opcode into the 4-bit ALU function code and drives operands to the combinational ALU.
- Captures the ALU result and presents a writeback packet (Rc, data, write-enable) over a second valid/ready handshake. It sits between register read and register writeback.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- ILLEGAL_RESULT, 32'h0000_0000, value returned in out_data for illegal opcodes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction/operands valid
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  Beta instruction: [31:26] opcode, [25:21] Rc, [20:16] Ra, [15:11] Rb, [15:0] literal
- in_ra_data  input  DATA_W  Reg[Ra]
- in_rb_data  input  DATA_W  Reg[Rb]
- alu_a  output  DATA_W  to ALU operand A
- alu_b  output  DATA_W  to ALU operand B
- alu_fn  output  4  to ALU function select
- alu_c  input  DATA_W  ALU result (combinational from alu_a/alu_b/alu_fn)
- out_valid  output  1  writeback packet valid
- out_ready  input  1  consumer accepts packet
- out_rc  output  5  destination register
- out_data  output  DATA_W  result
- out_we  output  1  register write enable
- out_illegal  output  1  packet came from an illegal opcode

Behaviour:
- Reset: asynchronous on rst_n low. All stage registers clear: s1_valid=0, out_valid=0, out_rc=0, out_data=0, out_we=0, out_illegal=0. alu_a, alu_b and alu_fn are driven from the cleared S1 register, so they read 0, 0, 4'b0000. Reset mid-operation discards all in-flight packets.
- Pipeline has two registered stages:
  - S1: decoded operands.
  - S2: output packet.
- Accept: in_valid && in_ready. Latency from accept to out_valid=1 is exactly 2 cycles when there is no backpressure.
- S2 advance condition: s2_adv = !out_valid || out_ready.
- in_ready = !s1_valid || s2_adv. This is a combinational path from out_ready; there is no skid buffer. Full throughput is 1 instruction per cycle.
- Decode on accept, latched into S1:
  - opcode[5:4] must be 2'b10 (OP) or 2'b11 (OPC). Otherwise the instruction is illegal.
  - opcode[3:0] in {0111, 1111} is illegal.
  - fn = opcode[3:0]. 1110 (SRA) is legal and passed through unchanged.
  - A = in_ra_data.
  - B = in_rb_data for OP. For OPC, B = literal[15:0] sign-extended to 32 bits.
  - Illegal instructions latch fn=4'b0000, A=0, B=0, illegal=1.
- S1 to S2 on s2_adv && s1_valid, registered:
  - out_data = alu_c, or ILLEGAL_RESULT if illegal.
  - out_rc = Rc.
  - out_illegal = illegal.
  - out_we = !illegal && (Rc != 31).
- out_valid:
  - Set when S1 moves to S2.
  - Cleared on out_ready when S1 is empty.
  - Held with all out_* stable while out_valid && !out_ready.
- S1 holds its contents, and therefore alu_* stay stable, while s1_valid && !s2_adv.
- Simultaneous accept and advance in the same cycle: S1 loads the new instruction while S2 loads the old one. No bubble, no loss.
- Packet order is strictly FIFO. No packet is ever dropped or duplicated.
- in_* are ignored while in_ready=0.

Test Plan:
1. ADD: in_instr opcode 0x20, Rc=3, ra=5, rb=7 -> 2 cycles later out_valid=1, out_data=12, out_rc=3, out_we=1, out_illegal=0. alu_fn=0000 during the S1 cycle.
2. OPC literal sign extension: opcode 0x31 (SUBC), ra=10, literal 0xFFFE -> alu_b=0xFFFF_FFFE, out_data=12. Opcode 0x3C (SHLC), ra=1, literal 4 -> out_data=16.
3. Illegal and R31: opcodes 0x27, 0x3F and 0x05 each give out_illegal=1, out_we=0, out_data=0. ADD with Rc=31 gives out_we=0, out_illegal=0, data valid.
4. Backpressure: stream 4 ADDs back-to-back with out_ready=0 after the first accept.
   - in_ready drops once S1 and S2 are full.
   - out_* hold stable.
   - Release out_ready -> packets retire one per cycle, in order, with correct results.
5. Throughput: 8 consecutive instructions with out_ready=1 -> 8 packets on 8 consecutive cycles starting at the 2-cycle latency. in_ready stays 1 throughout.
6. Reset mid-stream: assert rst_n=0 asynchronously with S1 and S2 full -> out_valid=0 and alu_fn=0 immediately. After release, the next instruction completes with normal 2-cycle latency and no stale packet appears.
